// File: rtl/act_pkg.sv
// Shared types and fixed-point constant helpers for the activation engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package act_pkg;

    typedef enum logic [1:0] {
        SIGMOID = 2'b00,
        TANH    = 2'b01,
        RELU    = 2'b10,
        PASS    = 2'b11
    } act_mode_e;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int q_one(input int frac_w);
        return 1 << frac_w;
    endfunction

    // num / 2^den_log2 in fixed point; exact as long as frac_w >= den_log2.
    function automatic int q_const(input int num, input int den_log2, input int frac_w);
        return (num << frac_w) >> den_log2;
    endfunction

endpackage

// File: rtl/activation_pipe_if.sv
// Input and output beat streams of the activation engine.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both streams.
interface activation_pipe_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_mode;
    logic [LANES*DATA_W-1:0] in_x;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_y;
    logic [LANES-1:0]        out_sat;

    // Upstream producer / downstream consumer view.
    modport master (
        output in_valid, in_mode, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_sat
    );

    // Activation engine view.
    modport slave (
        input  in_valid, in_mode, in_x, out_ready,
        output in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/act_lane.sv
// One lane: prescale/abs, piecewise-linear sigmoid region, reflect and mode map.
// Latency: 3 cycles, registers advance only when adv = 1.
// Backpressure: all stage registers hold while adv = 0.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  act_mode_e         mode,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    // Breakpoints and offsets of the sigmoid approximation. Magnitudes are
    // compared unsigned so 5.0 is representable even with 3 integer bits.
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(q_one(FRAC_W));
    localparam logic [DATA_W-1:0] SAT_BP  = DATA_W'(q_const(5, 0, FRAC_W));
    localparam logic [DATA_W-1:0] BP_HI   = DATA_W'(q_const(19, 3, FRAC_W));
    localparam logic [DATA_W-1:0] BP_LO   = DATA_W'(q_const(1, 0, FRAC_W));
    localparam logic [DATA_W-1:0] OFF_HI  = DATA_W'(q_const(27, 5, FRAC_W));
    localparam logic [DATA_W-1:0] OFF_MID = DATA_W'(q_const(5, 3, FRAC_W));
    localparam logic [DATA_W-1:0] OFF_LO  = DATA_W'(q_const(1, 1, FRAC_W));
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] xs;
    logic [DATA_W-1:0] xs_neg;
    logic              s_c;
    logic [DATA_W-1:0] a_c;

    logic              s0_s;
    logic [DATA_W-1:0] s0_a;
    act_mode_e         s0_mode;
    logic [DATA_W-1:0] s0_x;

    logic [DATA_W-1:0] lin_c;
    logic              sat_c;

    logic [DATA_W-1:0] s1_y;
    logic              s1_sat;
    logic              s1_s;
    act_mode_e         s1_mode;
    logic [DATA_W-1:0] s1_x;

    logic [DATA_W-1:0] refl;
    logic [DATA_W-1:0] out_c;
    logic              osat_c;

    // S0: tanh doubles the input (saturating), then split into sign and magnitude.
    always_comb begin
        xs = x;
        if (mode == TANH) begin
            if (x[DATA_W-1] != x[DATA_W-2]) begin
                xs = x[DATA_W-1] ? MIN_NEG : MAX_POS;
            end else begin
                xs = {x[DATA_W-2:0], 1'b0};
            end
        end
        s_c    = xs[DATA_W-1];
        xs_neg = -xs;
        a_c    = xs;
        if (s_c) begin
            a_c = (xs == MIN_NEG) ? MAX_POS : xs_neg;
        end
    end

    // S0 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_s    <= 1'b0;
            s0_a    <= '0;
            s0_mode <= SIGMOID;
            s0_x    <= '0;
        end else if (adv) begin
            s0_s    <= s_c;
            s0_a    <= a_c;
            s0_mode <= mode;
            s0_x    <= x;
        end
    end

    // S1: pick the linear segment for the magnitude; shifts truncate.
    always_comb begin
        sat_c = 1'b0;
        lin_c = (s0_a >> 2) + OFF_LO;
        if (s0_a >= SAT_BP) begin
            lin_c = ONE;
            sat_c = 1'b1;
        end else if (s0_a >= BP_HI) begin
            lin_c = (s0_a >> 5) + OFF_HI;
        end else if (s0_a >= BP_LO) begin
            lin_c = (s0_a >> 3) + OFF_MID;
        end
    end

    // S1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_y    <= '0;
            s1_sat  <= 1'b0;
            s1_s    <= 1'b0;
            s1_mode <= SIGMOID;
            s1_x    <= '0;
        end else if (adv) begin
            s1_y    <= lin_c;
            s1_sat  <= sat_c;
            s1_s    <= s0_s;
            s1_mode <= s0_mode;
            s1_x    <= s0_x;
        end
    end

    // S2: reflect negative inputs (sigmoid(-a) = 1 - sigmoid(a)), then map by mode.
    always_comb begin
        refl   = s1_s ? (ONE - s1_y) : s1_y;
        out_c  = s1_x;
        osat_c = 1'b0;
        case (s1_mode)
            SIGMOID: begin
                out_c  = refl;
                osat_c = s1_sat;
            end
            TANH: begin
                out_c  = (refl << 1) - ONE;
                osat_c = s1_sat;
            end
            RELU: begin
                out_c = s1_s ? '0 : s1_x;
            end
            PASS: begin
                out_c = s1_x;
            end
        endcase
    end

    // S2 / output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (adv) begin
            y   <= out_c;
            sat <= osat_c;
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// Multi-lane fixed-point activation engine (sigmoid/tanh/relu/passthrough).
// Latency: 3 cycles accept-to-valid, 1 beat/cycle sustained.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready mirrors that.
module activation_pipe
    import act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12,
    parameter int LANES  = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    activation_pipe_if.slave bus,
    output logic [CNT_W-1:0] beat_count
);

    logic              adv;
    logic [2:0]        stage_vld;
    act_mode_e         mode;
    logic [DATA_W-1:0] lane_y [LANES];
    logic [LANES-1:0]  lane_sat;

    // Bubbles travel with the data; only a full, unaccepted output stalls.
    assign adv          = ~stage_vld[2] | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = stage_vld[2];
    assign mode         = act_mode_e'(bus.in_mode);

    // Stage-valid chain shifts in lockstep with the lane datapaths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= '0;
        end else if (adv) begin
            stage_vld <= {stage_vld[1:0], bus.in_valid};
        end
    end

    // Completed output handshakes, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (stage_vld[2] & bus.out_ready) begin
            beat_count <= beat_count + 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .mode (mode),
            .x    (bus.in_x[g*DATA_W +: DATA_W]),
            .y    (lane_y[g]),
            .sat  (lane_sat[g])
        );
    end

    // Repack lane results onto the output bus.
    always_comb begin
        bus.out_y = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.out_y[i*DATA_W +: DATA_W] = lane_y[i];
        end
        bus.out_sat = lane_sat;
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Randomized and directed bench for activation_pipe against an arithmetic model.
// Latency: n/a.
// Backpressure: out_ready randomized during streaming phases.
module tb_activation_pipe;
    import act_pkg::*;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int LANES  = 4;
    localparam int CNT_W  = 32;
    localparam int ONE    = 1 << FRAC_W;
    localparam int MAXV   = (1 << (DATA_W-1)) - 1;
    localparam int MINV   = -(1 << (DATA_W-1));

    typedef struct packed {
        logic [LANES*DATA_W-1:0] y;
        logic [LANES-1:0]        sat;
    } exp_t;

    typedef struct packed {
        logic [1:0]        m;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              s;
    } dir_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] beat_count;
    bit               rnd_en = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t expq[$];
    int   hs_seen = 0;
    bit   prev_stall = 1'b0;
    logic [LANES*DATA_W-1:0] prev_y;
    logic [LANES-1:0]        prev_sat;

    activation_pipe_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    activation_pipe #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .LANES  (LANES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of one lane, straight from the activation rules.
    function automatic logic [DATA_W:0] model_lane(input logic [1:0] m, input logic [DATA_W-1:0] x);
        int xv, xs, a, yv, outv;
        bit s, sat;
        xv = int'($signed(x));
        xs = (m == 2'b01) ? 2 * xv : xv;
        if (xs > MAXV) xs = MAXV;
        if (xs < MINV) xs = MINV;
        s = (xs < 0);
        a = s ? -xs : xs;
        if (a > MAXV) a = MAXV;
        sat = 1'b0;
        if (a >= 5 * ONE) begin
            yv  = ONE;
            sat = 1'b1;
        end else if (8 * a >= 19 * ONE) begin
            yv = a / 32 + 27 * ONE / 32;
        end else if (a >= ONE) begin
            yv = a / 8 + 5 * ONE / 8;
        end else begin
            yv = a / 4 + ONE / 2;
        end
        if (s) yv = ONE - yv;
        case (m)
            2'b00:   outv = yv;
            2'b01:   outv = 2 * yv - ONE;
            2'b10:   begin outv = s ? 0 : xv; sat = 1'b0; end
            default: begin outv = xv; sat = 1'b0; end
        endcase
        return {sat, outv[DATA_W-1:0]};
    endfunction

    function automatic exp_t model_beat(input logic [1:0] m, input logic [LANES*DATA_W-1:0] x);
        exp_t e;
        logic [DATA_W:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = model_lane(m, x[i*DATA_W +: DATA_W]);
            e.y[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
            e.sat[i] = r[DATA_W];
        end
        return e;
    endfunction

    // Random lane value biased toward breakpoints and extremes.
    function automatic logic [DATA_W-1:0] rand_x();
        logic [DATA_W-1:0] v;
        int pick;
        int bps [8] = '{ONE, ONE-1, 19*ONE/8, 19*ONE/8-1, 5*ONE, 5*ONE-1, 5*ONE/2, 0};
        v = DATA_W'($urandom);
        case ($urandom_range(0, 4))
            0: v = DATA_W'($urandom);
            1: v = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            2: begin
                pick = bps[$urandom_range(0, 7)];
                v = DATA_W'(($urandom_range(0, 1) == 1) ? -pick : pick);
            end
            3: v = DATA_W'(int'($urandom_range(0, 12*ONE)) - 6*ONE);
            default: v = DATA_W'(int'($urandom_range(0, 2*ONE)) - ONE);
        endcase
        return v;
    endfunction

    function automatic logic [LANES*DATA_W-1:0] rand_vec();
        logic [LANES*DATA_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = rand_x();
        return v;
    endfunction

    // Consumer readiness: random during streaming, otherwise always ready.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Compare process: scoreboard, stall stability and beat counter every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            hs_seen    = 0;
            prev_stall = 1'b0;
        end else begin
            check("beat_count", 64'(beat_count), 64'(hs_seen));
            if (prev_stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_y", 64'(bus.out_y), 64'(prev_y));
                check("stall_sat", 64'(bus.out_sat), 64'(prev_sat));
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model_beat(bus.in_mode, bus.in_x));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got y=%0h expected no beat", bus.out_y);
                end else begin
                    e = expq.pop_front();
                    check("beat_y", 64'(bus.out_y), 64'(e.y));
                    check("beat_sat", 64'(bus.out_sat), 64'(e.sat));
                end
                hs_seen++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_y     = bus.out_y;
            prev_sat   = bus.out_sat;
        end
    end

    // Present one beat; entered and left at #1 after a rising edge.
    task automatic drive_beat(input logic [1:0] m, input logic [LANES*DATA_W-1:0] x);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_x     = x;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end
        bus.in_valid = 1'b0;
    endtask

    // Single beat with lane 0 pinned to a hand-computed result; checks latency too.
    task automatic directed(input int idx, input dir_t d);
        logic [LANES*DATA_W-1:0] v;
        int lat;
        @(posedge clk);
        #1;
        v = rand_vec();
        v[DATA_W-1:0] = d.x;
        drive_beat(d.m, v);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check($sformatf("dir%0d_latency", idx), 64'(lat), 64'd3);
        check($sformatf("dir%0d_y", idx), 64'(bus.out_y[DATA_W-1:0]), 64'(d.y));
        check($sformatf("dir%0d_sat", idx), 64'(bus.out_sat[0]), 64'(d.s));
        @(negedge clk);
        check($sformatf("dir%0d_one_cycle", idx), 64'(bus.out_valid), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", expq.size());
        end
    endtask

    dir_t dirs [18] = '{
        '{2'b00, 16'h0000, 16'h0800, 1'b0},
        '{2'b00, 16'h1000, 16'h0C00, 1'b0},
        '{2'b00, 16'hF000, 16'h0400, 1'b0},
        '{2'b00, 16'hC000, 16'h0080, 1'b0},
        '{2'b00, 16'h5000, 16'h1000, 1'b1},
        '{2'b00, 16'h8000, 16'h0000, 1'b1},
        '{2'b00, 16'h7FFF, 16'h1000, 1'b1},
        '{2'b00, 16'h2600, 16'h0EB0, 1'b0},
        '{2'b00, 16'h25FF, 16'h0EBF, 1'b0},
        '{2'b00, 16'h4FFF, 16'h0FFF, 1'b0},
        '{2'b00, 16'h0FFF, 16'h0BFF, 1'b0},
        '{2'b01, 16'h8000, 16'hF000, 1'b1},
        '{2'b01, 16'h0800, 16'h0800, 1'b0},
        '{2'b01, 16'h0000, 16'h0000, 1'b0},
        '{2'b01, 16'h2800, 16'h1000, 1'b1},
        '{2'b10, 16'hD000, 16'h0000, 1'b0},
        '{2'b10, 16'h2345, 16'h2345, 1'b0},
        '{2'b11, 16'h8000, 16'h8000, 1'b0}
    };

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Pin the model itself to hand-computed points.
        check("model_sig_m4", 64'(model_lane(2'b00, 16'hC000)), {47'd0, 1'b0, 16'h0080});
        check("model_tanh_min", 64'(model_lane(2'b01, 16'h8000)), {47'd0, 1'b1, 16'hF000});
        check("model_tanh_half", 64'(model_lane(2'b01, 16'h0800)), {47'd0, 1'b0, 16'h0800});
        check("model_relu_neg", 64'(model_lane(2'b10, 16'hD000)), {47'd0, 1'b0, 16'h0000});

        // Directed points with literal lane-0 results.
        for (int i = 0; i < 18; i++) directed(i, dirs[i]);

        // Streaming: 20 back-to-back mixed-mode beats from a clean counter.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnd_en = 1'b1;
        for (int k = 0; k < 20; k++) drive_beat(2'($urandom_range(0, 3)), rand_vec());
        drain();
        rnd_en = 1'b0;
        @(negedge clk);
        check("stream_beat_count", 64'(beat_count), 64'd20);

        // Longer randomized run with gaps and random backpressure.
        rnd_en = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_beat(2'($urandom_range(0, 3)), rand_vec());
        end
        drain();
        rnd_en = 1'b0;

        // Reset with three beats in flight.
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) drive_beat(2'($urandom_range(0, 3)), rand_vec());
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_beat_count", 64'(beat_count), 64'd0);
        check("midrst_out_y", 64'(bus.out_y), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        directed(100, '{2'b00, 16'h1000, 16'h0C00, 1'b0});
        check("midrst_after_count", 64'(beat_count), 64'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Parametrised fixed-point activation engine; successor to the single-lane float sigmoid approximator.
- Processes LANES signed Q-format values per beat.
- Runtime mode: sigmoid (PLAN piecewise-linear), tanh (derived from sigmoid), ReLU, or passthrough.
- Full-throughput 3-stage pipeline with valid/ready handshake on both sides; sits between the MAC array output and layer writeback.

Parameters:
- DATA_W, 16, total signed width per lane (two's complement).
- FRAC_W, 12, fractional bits; constraint FRAC_W >= 5 and DATA_W - FRAC_W >= 3.
- LANES, 4, number of parallel lanes.
- CNT_W, 32, width of the completed-beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mode  in  2  00 sigmoid, 01 tanh, 10 relu, 11 passthrough; sampled with the beat.
- in_x  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_y  out  LANES*DATA_W  results, same Q format and packing as in_x.
- out_sat  out  LANES  per-lane flag: input fell in a saturation region.
- beat_count  out  CNT_W  count of completed output handshakes; wraps.

Behaviour:
- Reset: all stage valids = 0; out_valid = 0, out_y = 0, out_sat = 0, beat_count = 0; in_ready = 1 after reset.
- Pipeline advance: adv = ~out_valid | out_ready; in_ready = adv; all stages shift together when adv = 1. Bubbles are not collapsed.
- Beat acceptance: a beat is accepted when in_valid & in_ready.
- Latency and throughput: out_valid rises 3 cycles after acceptance with no stall; 1 beat/cycle sustained.
- Stall: while out_valid & ~out_ready, out_y, out_sat and all stage contents hold stable.
- beat_count increments on out_valid & out_ready and wraps modulo 2^CNT_W.
- Constants: ONE = 1<<FRAC_W.
- S0 (prescale):
  - tanh mode: xs = 2x with saturation to DATA_W signed limits.
  - all other modes: xs = x.
  - s = sign(xs); a = |xs|, with the most-negative value mapping to max positive.
- S1 (region and linear term):
  - a >= 5*ONE: y = ONE, sat = 1.
  - a >= 19*ONE/8: y = (a>>5) + 27*ONE/32.
  - a >= ONE: y = (a>>3) + 5*ONE/8.
  - else: y = (a>>2) + ONE/2.
  - Shifts are arithmetic on non-negative a, i.e. truncation.
- S2 (reflect and map):
  - If s: y = ONE - y.
  - tanh: out = 2y - ONE; sat from S1.
  - relu: out = s ? 0 : x; sat = 0.
  - passthrough: out = x; sat = 0.
- Mode is carried per beat through the pipeline; different modes in flight are legal.
- Mid-operation reset: in-flight beats are discarded, no output handshake occurs, beat_count clears.
- Simultaneous input and output handshake in the same cycle: both complete and the pipe shifts.

Decomposition:
- Package act_pkg:
  - act_mode_e enum (SIGMOID, TANH, RELU, PASS).
  - functions q_one(FRAC_W) and q_const(num, den_log2, FRAC_W) for the breakpoint and offset constants.
- Sub-module act_lane: one lane's 3-stage datapath, with enable input adv.
  - Instantiated LANES times via generate.
- Top-level owns: stage-valid chain, adv/in_ready logic, beat_count.

Test Plan (defaults, Q4.12; lane 0 shown, other lanes given distinct values):
- Sigmoid points: x = 0x0000, 0x1000 (1.0), 0xF000 (-1.0), 0xC000 (-4.0), 0x5000 (5.0) -> 0x0800, 0x0C00, 0x0400, 0x0080, 0x1000; sat = 1 only for 5.0.
- Edge input: x = 0x8000 (most negative) in sigmoid -> out_y = 0x0000, sat = 1; same value in tanh -> 0xF000, sat = 1.
- Tanh and ReLU: tanh x = 0x0800 (0.5) -> 0x0800; tanh x = 0 -> 0x0000; relu x = 0xD000 -> 0x0000; relu x = 0x2345 -> 0x2345.
- Streaming with backpressure: 20 back-to-back beats with mixed modes and out_ready toggling randomly -> results in order, no loss or duplication, out_y stable during stalls, beat_count = 20.
- Latency: single beat with out_ready = 1 accepted at cycle N -> out_valid at N+3 for exactly 1 cycle.
- Reset mid-flight: assert rst with 3 beats in flight -> out_valid = 0 immediately, beat_count = 0, in_ready = 1 after release, next beat is processed correctly.
